// File: rtl/uart_cmd_wrapper_if.sv
// uart_cmd_wrapper_if: command/response handshake between the UART endpoint and the command processor.
interface uart_cmd_wrapper_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        tx_busy;
    logic        resp_sent;
    logic        frm_err;
    modport master (
        input  cmd, cmd_rdy, tx_busy, resp_sent, frm_err,
        output clr_cmd_rdy, resp, send_resp
    );
    modport slave (
        output cmd, cmd_rdy, tx_busy, resp_sent, frm_err,
        input  clr_cmd_rdy, resp, send_resp
    );
endinterface

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: 8N1 UART endpoint assembling two-byte commands and serialising one-byte responses.
// Define CMD_TIMEOUT_EN to drop a held high byte when the low byte does not arrive within TIMEOUT cycles.
module uart_cmd_wrapper #(
    parameter int BAUD_DIV = 2604,
    parameter int TIMEOUT  = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic RX,
    output logic TX,
    uart_cmd_wrapper_if.slave bus
);
    localparam logic [11:0] BIT_END  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_END = 12'(BAUD_DIV / 2 - 1);
    if (BAUD_DIV < 8 || BAUD_DIV > 4095 || TIMEOUT < 1) begin : g_bad_param
        $error("uart_cmd_wrapper: parameter out of range");
    end
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {WAIT_HIGH, WAIT_LOW} w_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    rx_state_t   rx_state;
    logic        rx_s1, rx_s2, rx_prev;
    logic [11:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_tick, rx_vld, rx_bad;
    w_state_t    w_state;
    logic [7:0]  hi;
    logic [15:0] cmd;
    logic        cmd_rdy, frm_err;
    tx_state_t   tx_state;
    logic [11:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic [8:0]  tx_sh;
    logic        tx_busy, resp_sent;
    assign rx_tick = rx_cnt == BIT_END;
    assign rx_vld  = rx_state == RX_STOP && rx_tick && rx_s2;
    assign rx_bad  = rx_state == RX_STOP && rx_tick && !rx_s2;
    assign bus.cmd       = cmd;
    assign bus.cmd_rdy   = cmd_rdy;
    assign bus.frm_err   = frm_err;
    assign bus.tx_busy   = tx_busy;
    assign bus.resp_sent = resp_sent;
    // Synchroniser presets high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            frm_err  <= 1'b0;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            frm_err <= rx_bad;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s2) rx_state <= RX_START;
                end
                RX_START: begin
                    rx_cnt <= rx_cnt == HALF_END ? '0 : rx_cnt + 1'b1;
                    rx_bit <= '0;
                    if (rx_cnt == HALF_END) rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
                    if (rx_tick) begin
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_bit <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
                    if (rx_tick) rx_state <= RX_IDLE;
                end
            endcase
        end
    end
`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_END = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt;
    always_ff @(posedge clk) begin
        if (rst || w_state != WAIT_LOW || rx_vld || rx_bad) to_cnt <= '0;
        else to_cnt <= to_cnt + 1'b1;
    end
`endif
    // A completing command is written after the clear so that set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= WAIT_HIGH;
            hi      <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            if (bus.clr_cmd_rdy) cmd_rdy <= 1'b0;
            if (rx_bad) w_state <= WAIT_HIGH;
            else if (rx_vld && w_state == WAIT_HIGH) begin
                hi      <= rx_sh;
                cmd_rdy <= 1'b0;
                w_state <= WAIT_LOW;
            end else if (rx_vld) begin
                cmd     <= {hi, rx_sh};
                cmd_rdy <= 1'b1;
                w_state <= WAIT_HIGH;
            end
`ifdef CMD_TIMEOUT_EN
            else if (w_state == WAIT_LOW && to_cnt == TO_END) w_state <= WAIT_HIGH;
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            TX        <= 1'b1;
            tx_busy   <= 1'b0;
            resp_sent <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '1;
        end else begin
            resp_sent <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (bus.send_resp) begin
                        tx_sh    <= {1'b1, bus.resp};
                        TX       <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_state <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    tx_cnt <= tx_cnt == BIT_END ? '0 : tx_cnt + 1'b1;
                    if (tx_cnt == BIT_END && tx_bit == 4'd9) begin
                        TX        <= 1'b1;
                        tx_busy   <= 1'b0;
                        resp_sent <= 1'b1;
                        tx_state  <= TX_IDLE;
                    end else if (tx_cnt == BIT_END) begin
                        TX     <= tx_sh[0];
                        tx_sh  <= {1'b1, tx_sh[8:1]};
                        tx_bit <= tx_bit + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb_uart_cmd_wrapper: directed and random stimulus against a byte-pair command model and a frame-level TX model.
module tb_uart_cmd_wrapper;
    localparam int BD = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic RX = 1'b1;
    logic TX;
    uart_cmd_wrapper_if bus();
    uart_cmd_wrapper #(.BAUD_DIV(BD), .TIMEOUT(500)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .bus(bus)
    );
    always #5 clk = ~clk;
    int n_cmp = 0;
    int n_bad = 0;
    logic        have_hi = 1'b0;
    logic [7:0]  pend_hi = '0;
    logic [15:0] exp_cmd = '0;
    logic        exp_rdy = 1'b0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic model_byte(input logic [7:0] b, input logic ok);
        if (!ok) have_hi = 1'b0;
        else if (!have_hi) begin
            pend_hi = b;
            have_hi = 1'b1;
            exp_rdy = 1'b0;
        end else begin
            exp_cmd = {pend_hi, b};
            exp_rdy = 1'b1;
            have_hi = 1'b0;
        end
    endtask
    task automatic model_reset();
        have_hi = 1'b0;
        exp_cmd = '0;
        exp_rdy = 1'b0;
    endtask
    task automatic send_bits(input logic [9:0] fr, input int nb);
        for (int i = 0; i < nb; i++) begin
            RX = fr[i];
            repeat (BD) @(negedge clk);
        end
    endtask
    task automatic send_byte(input logic [7:0] b, input logic stopv, input logic hold_clr);
        logic [9:0] fr;
        logic fe, set_seen;
        fr = {stopv, b, 1'b0};
        fe = 1'b0;
        set_seen = 1'b0;
        if (hold_clr) bus.clr_cmd_rdy = 1'b1;
        send_bits(fr, 9);
        check("rdy_pre_stop", bus.cmd_rdy, exp_rdy);
        RX = stopv;
        for (int i = 0; i < BD; i++) begin
            @(negedge clk);
            if (bus.frm_err) fe = 1'b1;
            if (hold_clr && bus.cmd_rdy && !set_seen) begin
                set_seen = 1'b1;
                bus.clr_cmd_rdy = 1'b0;
            end
        end
        model_byte(b, stopv);
        check("frm_err", fe, !stopv);
        if (hold_clr) check("set_wins", set_seen, 1);
        check("cmd_rdy", bus.cmd_rdy, exp_rdy);
        check("cmd", bus.cmd, exp_cmd);
        bus.clr_cmd_rdy = 1'b0;
        if (!stopv) begin
            RX = 1'b1;
            repeat (BD) @(negedge clk);
        end
    endtask
    task automatic do_clear();
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
        check("clr", bus.cmd_rdy, exp_rdy);
    endtask
    task automatic tx_chk(input logic [7:0] r);
        logic [9:0] fr;
        fr = {1'b1, r, 1'b0};
        bus.resp = r;
        bus.send_resp = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
        check("tx_busy_rise", bus.tx_busy, 1);
        for (int j = 0; j < 10 * BD; j++) begin
            check("tx_bit", TX, fr[j / BD]);
            check("tx_busy_hold", bus.tx_busy, 1);
            check("resp_sent_early", bus.resp_sent, 0);
            if (j == 50) begin
                bus.resp = ~r;
                bus.send_resp = 1'b1;
            end
            if (j == 51) bus.send_resp = 1'b0;
            if (j == 10 * BD - 1) bus.send_resp = 1'b1;
            @(negedge clk);
        end
        bus.send_resp = 1'b0;
        check("resp_sent", bus.resp_sent, 1);
        check("tx_busy_fall", bus.tx_busy, 0);
        check("tx_idle", TX, 1);
        @(negedge clk);
        check("late_send_ignored", bus.tx_busy, 0);
        check("resp_sent_pulse", bus.resp_sent, 0);
    endtask
    initial begin
        bus.clr_cmd_rdy = 1'b0;
        bus.resp = '0;
        bus.send_resp = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", TX, 1);
        check("rst_cmd", bus.cmd, 0);
        check("rst_rdy", bus.cmd_rdy, 0);
        check("rst_busy", bus.tx_busy, 0);
        check("rst_sent", bus.resp_sent, 0);
        check("rst_ferr", bus.frm_err, 0);
        rst = 1'b0;
        repeat (2 * BD) @(negedge clk);
        send_byte(8'hA5, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("rdy_hold", bus.cmd_rdy, 1);
        check("cmd_hold", bus.cmd, 16'hA53C);
        do_clear();
        tx_chk(8'hA5);
        send_byte(8'h77, 1'b1, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0);
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0);
        do_clear();
        send_byte(8'hBE, 1'b1, 1'b0);
        send_byte(8'hEF, 1'b1, 1'b1);
        @(negedge clk);
        check("beef_rdy", bus.cmd_rdy, 1);
        check("beef_cmd", bus.cmd, 16'hBEEF);
        do_clear();
        bus.resp = 8'h5A;
        bus.send_resp = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
        send_bits({1'b1, 8'h55, 1'b0}, 5);
        RX = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check("mid_rst_tx", TX, 1);
        check("mid_rst_busy", bus.tx_busy, 0);
        check("mid_rst_cmd", bus.cmd, exp_cmd);
        check("mid_rst_rdy", bus.cmd_rdy, exp_rdy);
        rst = 1'b0;
        repeat (2 * BD) @(negedge clk);
        check("mid_rst_tx_idle", TX, 1);
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (2 * BD) @(negedge clk);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b0);
        check("glitch_cmd", bus.cmd, 16'h55AA);
        do_clear();
        for (int k = 0; k < 10; k++) begin
            send_byte(8'($urandom), $urandom_range(0, 4) != 0, 1'b0);
            if ($urandom_range(0, 1) == 1) do_clear();
        end
        for (int k = 0; k < 2; k++) tx_chk(8'($urandom));
`ifdef CMD_TIMEOUT_EN
        if (have_hi) send_byte(8'h00, 1'b1, 1'b0);
        do_clear();
        send_byte(8'h11, 1'b1, 1'b0);
        repeat (600) @(negedge clk);
        have_hi = 1'b0;
        check("to_no_rdy", bus.cmd_rdy, 0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        check("to_cmd", bus.cmd, 16'h2233);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
- Remote-side endpoint of the command link. Receives the two-byte command stream produced by the command master (high byte first), assembles it into a 16-bit command, and presents it to the command processor with a ready/clear handshake.
- Serialises an 8-bit response (e.g. 0xA5 ack) back to the master.
- Contains its own 8N1 UART receiver and transmitter.

Parameters:
- BAUD_DIV, 2604, clock cycles per bit (50 MHz / 19200 baud); legal range 8..4095.
- TIMEOUT, 1000000, cycles allowed between high-byte stop and low-byte stop (used only with CMD_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- RX  input  1  serial in from master (asynchronous, idles high)
- TX  output  1  serial out to master (idles high)
- cmd  output  16  assembled command {high, low}
- cmd_rdy  output  1  command valid; level, held until cleared
- clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy
- resp  input  8  response byte to send
- send_resp  input  1  one-cycle request to transmit resp
- tx_busy  output  1  transmitter active
- resp_sent  output  1  one-cycle pulse when response stop bit completes
- frm_err  output  1  one-cycle pulse when a received stop bit samples 0

Behaviour:
- Reset values: TX=1, cmd=0, cmd_rdy=0, tx_busy=0, resp_sent=0, frm_err=0. All FSMs go to idle and all counters clear.
- Reset is synchronous. Asserting rst mid-frame aborts both RX and TX immediately; TX returns to 1 on the next edge.
- RX synchroniser: two flops, preset to 1 on reset. Start is detected on a 1->0 transition of the synchronised RX.
- RX FSM (RX_IDLE, RX_START, RX_DATA, RX_STOP):
  - Sampling: half-bit count (BAUD_DIV/2) to the start-bit middle; if the line is back at 1 there, it was a glitch, so return to RX_IDLE. After that, sample at full BAUD_DIV intervals.
  - Data: LSB first, 8 bits.
  - Stop bit = 1: the byte is valid for one cycle (internal rx_vld).
  - Stop bit = 0: frm_err pulses, the byte is dropped, and the wrapper FSM returns to WAIT_HIGH.
- Wrapper FSM (WAIT_HIGH, WAIT_LOW):
  - rx_vld in WAIT_HIGH: latch the high byte, clear cmd_rdy, go to WAIT_LOW.
  - rx_vld in WAIT_LOW: on the next edge cmd={high,low} and cmd_rdy=1, then go to WAIT_HIGH.
  - cmd is stable while cmd_rdy=1 and changes only on command completion.
- cmd_rdy handshake: clr_cmd_rdy clears it on the next edge. If clr_cmd_rdy coincides with command completion, set wins. clr_cmd_rdy while cmd_rdy=0 has no effect.
- Latency: cmd_rdy rises 1 cycle after the low-byte stop-bit sample, i.e. ~19.5 bit times after the high-byte start edge when back-to-back.
- TX FSM (TX_IDLE, TX_SHIFT):
  - send_resp in TX_IDLE: capture resp; tx_busy=1 on the next edge.
  - Frame: 10 bits (0, d0..d7, 1), each exactly BAUD_DIV cycles.
  - After 10*BAUD_DIV cycles: resp_sent pulses and tx_busy falls on the same edge.
  - send_resp while tx_busy=1 is ignored (no queuing).
  - send_resp in the same cycle tx_busy falls is ignored; it is accepted from the following cycle.
- RX and TX are fully independent (full duplex).

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined: a counter runs in WAIT_LOW. If it reaches TIMEOUT before the low byte is received, the held high byte is discarded and the FSM returns to WAIT_HIGH. No cmd_rdy results, and the next received byte is treated as a high byte.
- Not defined: WAIT_LOW waits indefinitely; there is no counter logic.

Test Plan:
- BAUD_DIV=16: reset, master sends 0xA5 then 0x3C -> cmd=16'hA53C, cmd_rdy=1 one cycle after the second stop sample; cmd_rdy holds until clr_cmd_rdy, then 0 next cycle.
- send_resp with resp=8'hA5 -> TX shows 0,1,0,1,0,0,1,0,1,1 for 16 cycles each. resp_sent pulses 160 cycles after tx_busy rose, then tx_busy=0. A second send_resp at cycle 50 is ignored.
- Low byte sent with stop bit forced 0 -> frm_err pulse, cmd_rdy stays 0. A following 0x12,0x34 yields cmd=16'h1234.
- clr_cmd_rdy asserted in the exact completion cycle of 0xBEEF -> cmd_rdy=1, cmd=16'hBEEF.
- rst asserted mid high-byte; then 0x55,0xAA sent -> cmd=16'h55AA. A 4-cycle RX low glitch produces no byte.
- CMD_TIMEOUT_EN, TIMEOUT=500: high byte 0x11, idle 600 cycles, then 0x22,0x33 -> cmd=16'h2233, no command containing 0x11.
